// File: rtl/alu_divider.sv
// Iterative restoring divider for the ALU controller's divide/modulus operations.
// One quotient bit per enabled clock; results are registered and held until the next FINISH.
module alu_divider #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clken,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] divq,
   output logic [WIDTH-1:0] divr,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   q_q, q_d;
   logic [WIDTH-1:0]   d_q, d_d;
   // The partial remainder never exceeds D-1, so WIDTH bits hold it between
   // iterations; only the shifted trial value needs the extra bit.
   logic [WIDTH-1:0]   r_q, r_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   divq_q, divq_d;
   logic [WIDTH-1:0]   divr_q, divr_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               div_zero_q, div_zero_d;

   logic [WIDTH:0]     r_shift;
   logic [WIDTH:0]     r_trial;
   logic               fits;

   always_comb begin
      r_shift = {r_q, q_q[WIDTH-1]};
      r_trial = r_shift - {1'b0, d_q};
      fits    = (r_shift >= {1'b0, d_q});
   end

   always_comb begin
      state_d    = state_q;
      q_d        = q_q;
      d_d        = d_q;
      r_d        = r_q;
      cnt_d      = cnt_q;
      divq_d     = divq_q;
      divr_d     = divr_q;
      busy_d     = busy_q;
      done_d     = done_q;
      div_zero_d = div_zero_q;

      case (state_q)
         S_IDLE: begin
            done_d = 1'b0;
            if (start) begin
               q_d    = dividend;
               d_d    = divisor;
               r_d    = '0;
               cnt_d  = CNT_W'(WIDTH);
               busy_d = 1'b1;
               // A zero divisor skips iteration entirely; FINISH substitutes the fixed result.
               state_d = (divisor == '0) ? S_FINISH : S_RUN;
            end
         end

         S_RUN: begin
            done_d = 1'b0;
            q_d    = {q_q[WIDTH-2:0], fits};
            r_d    = fits ? r_trial[WIDTH-1:0] : r_shift[WIDTH-1:0];
            cnt_d  = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1))
               state_d = S_FINISH;
         end

         S_FINISH: begin
            if (d_q == '0) begin
               divq_d     = '1;
               divr_d     = q_q;
               div_zero_d = 1'b1;
            end else begin
               divq_d     = q_q;
               divr_d     = r_q;
               div_zero_d = 1'b0;
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         q_q        <= '0;
         d_q        <= '0;
         r_q        <= '0;
         cnt_q      <= '0;
         divq_q     <= '0;
         divr_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
      end else if (clken) begin
         state_q    <= state_d;
         q_q        <= q_d;
         d_q        <= d_d;
         r_q        <= r_d;
         cnt_q      <= cnt_d;
         divq_q     <= divq_d;
         divr_q     <= divr_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign divq     = divq_q;
   assign divr     = divr_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = div_zero_q;

endmodule

// File: tb/tb_alu_divider.sv
// Self-checking bench for alu_divider: directed cases plus a random sweep
// compared against plain integer division.
module tb_alu_divider;

   localparam int WIDTH = 16;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             clken = 1'b1;
   logic             start = 1'b0;
   logic [WIDTH-1:0] dividend = '0;
   logic [WIDTH-1:0] divisor = '0;
   logic [WIDTH-1:0] divq;
   logic [WIDTH-1:0] divr;
   logic             busy;
   logic             done;
   logic             div_zero;

   int n_cmp = 0;
   int n_bad = 0;
   int done_cnt = 0;

   alu_divider #(.WIDTH(WIDTH), .CNT_W(5)) dut (
      .clock    (clock),
      .reset    (reset),
      .clken    (clken),
      .start    (start),
      .dividend (dividend),
      .divisor  (divisor),
      .divq     (divq),
      .divr     (divr),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (!reset && clken && done)
         done_cnt <= done_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // mode 0: plain, 1: re-pulse start at cycle 5, 2: clken low for 4 cycles,
   // 3: reset at cycle 8. Called and returns at #1 after a rising edge.
   task automatic do_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input int mode, input string name);
      int cyc;
      int busy_cyc;
      int dc0;
      int exp_lat;
      logic [WIDTH-1:0] eq, er;
      logic ez;

      dc0 = done_cnt;
      start = 1'b1; dividend = a; divisor = b;
      @(posedge clock); #1;
      start = 1'b0;
      dividend = WIDTH'($urandom); divisor = WIDTH'($urandom);
      check({name, "_busy_after_start"}, 32'(busy), 32'd1);
      cyc = 0;
      busy_cyc = 0;
      while (!done && cyc < 60) begin
         if (busy) busy_cyc++;
         if (mode == 1 && cyc == 5) begin
            start = 1'b1; dividend = 16'd77; divisor = 16'd3;
         end
         if (mode == 1 && cyc == 6) start = 1'b0;
         if (mode == 2 && cyc == 6) clken = 1'b0;
         if (mode == 2 && cyc == 10) clken = 1'b1;
         if (mode == 3 && cyc == 8) begin
            reset = 1'b1;
            #1;
            check({name, "_rst_divq"}, 32'(divq), 32'd0);
            check({name, "_rst_divr"}, 32'(divr), 32'd0);
            check({name, "_rst_busy"}, 32'(busy), 32'd0);
            check({name, "_rst_done"}, 32'(done), 32'd0);
            check({name, "_rst_dz"}, 32'(div_zero), 32'd0);
            @(posedge clock); #1;
            reset = 1'b0;
            repeat (25) begin @(posedge clock); #1; end
            check({name, "_rst_no_done"}, 32'(done_cnt - dc0), 32'd0);
            check({name, "_rst_idle"}, 32'(busy), 32'd0);
            return;
         end
         @(posedge clock); #1;
         cyc++;
      end
      check({name, "_done_seen"}, 32'(done), 32'd1);

      if (b == '0) begin
         eq = '1; er = a; ez = 1'b1; exp_lat = 1;
      end else begin
         eq = a / b; er = a % b; ez = 1'b0; exp_lat = WIDTH + 1;
      end
      if (mode == 2) exp_lat += 4;
      check({name, "_latency"}, 32'(cyc), 32'(exp_lat));
      check({name, "_busy_cycles"}, 32'(busy_cyc), 32'(exp_lat));
      check({name, "_divq"}, 32'(divq), 32'(eq));
      check({name, "_divr"}, 32'(divr), 32'(er));
      check({name, "_dz"}, 32'(div_zero), 32'(ez));
      check({name, "_busy_end"}, 32'(busy), 32'd0);
      @(posedge clock); #1;
      check({name, "_done_pulses"}, 32'(done_cnt - dc0), 32'd1);
      check({name, "_done_low"}, 32'(done), 32'd0);
      check({name, "_hold_divq"}, 32'(divq), 32'(eq));
      $display("div %0d / %0d -> q=%0d r=%0d dz=%0d lat=%0d (%s)",
               a, b, divq, divr, div_zero, cyc, name);
   endtask

   initial begin
      logic [WIDTH-1:0] ra, rb;

      repeat (2) @(posedge clock);
      #1;
      check("reset_divq", 32'(divq), 32'd0);
      check("reset_divr", 32'(divr), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_dz", 32'(div_zero), 32'd0);
      reset = 1'b0;
      @(posedge clock); #1;

      do_div(16'd100, 16'd7, 0, "d100_7");
      do_div(16'hFFFF, 16'd1, 0, "dffff_1");
      do_div(16'd5, 16'd9, 0, "d5_9");
      do_div(16'h1234, 16'd0, 0, "dzero");
      do_div(16'd10, 16'd3, 0, "d10_3");
      do_div(16'd1000, 16'd10, 1, "restart_ignored");
      do_div(16'd50000, 16'd123, 2, "clken_stall");

      // done must hold through a disabled edge: stall right as it rises.
      start = 1'b1; dividend = 16'd9; divisor = 16'd0;
      @(posedge clock); #1;
      start = 1'b0;
      @(posedge clock); #1;
      clken = 1'b0;
      @(posedge clock); #1;
      check("done_held_clken", 32'(done), 32'd1);
      clken = 1'b1;
      @(posedge clock); #1;
      check("done_after_clken", 32'(done), 32'd0);

      do_div(16'd3000, 16'd7, 3, "reset_mid_run");
      do_div(16'd81, 16'd9, 0, "d81_9_after_reset");

      for (int i = 0; i < 2000; i++) begin
         ra = WIDTH'($urandom);
         case ($urandom_range(0, 3))
            0: rb = WIDTH'($urandom_range(0, 15));
            1: rb = WIDTH'($urandom_range(0, 255));
            default: rb = WIDTH'($urandom);
         endcase
         do_div(ra, rb, 0, "random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
